// File: rtl/aes_dec_pkg.sv
// ============================================================================
// Module      : aes_dec_pkg
// Description : Shared types and constants for the AES-128 decrypt sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes_dec_pkg;

  localparam int NR_DEF = 10;
  localparam int KIDX_W = 4;
  localparam int SRC_W  = 3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARK0 = 3'd1,
    ST_ISR  = 3'd2,
    ST_ISB  = 3'd3,
    ST_ARK  = 3'd4,
    ST_IMC  = 3'd5,
    ST_DONE = 3'd6
  } state_t;

  localparam logic [SRC_W-1:0] SRC_IN  = 3'd0;
  localparam logic [SRC_W-1:0] SRC_ISR = 3'd1;
  localparam logic [SRC_W-1:0] SRC_ISB = 3'd2;
  localparam logic [SRC_W-1:0] SRC_ARK = 3'd3;
  localparam logic [SRC_W-1:0] SRC_IMC = 3'd4;

endpackage

`default_nettype wire

// File: rtl/aes_dec_round_ctrl_if.sv
// ============================================================================
// Module      : aes_dec_round_ctrl_if
// Description : Handshake and stage-control bundle of the decrypt sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface aes_dec_round_ctrl_if #(
  parameter int KIDX_W = aes_dec_pkg::KIDX_W
);
  import aes_dec_pkg::*;

  logic              key_ready;
  logic              in_valid;
  logic              in_ready;
  logic              abort;
  logic              isr_start;
  logic              isb_start;
  logic              ark_start;
  logic              imc_start;
  logic [SRC_W-1:0]  src_sel;
  logic [KIDX_W-1:0] key_idx;
  logic              busy;
  logic              out_valid;
  logic              out_ready;

  // master = wrapper side, slave = sequencer
  modport master (
    output key_ready, in_valid, abort, out_ready,
    input  in_ready, isr_start, isb_start, ark_start, imc_start,
    input  src_sel, key_idx, busy, out_valid
  );

  modport slave (
    input  key_ready, in_valid, abort, out_ready,
    output in_ready, isr_start, isb_start, ark_start, imc_start,
    output src_sel, key_idx, busy, out_valid
  );

endinterface

`default_nettype wire

// File: rtl/aes_round_counter.sv
// ============================================================================
// Module      : aes_round_counter
// Description : Round down-counter with load of NR-1, decrement and zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_round_counter #(
  parameter int NR = 10,
  parameter int W  = 4
) (
  input  wire logic         clk,
  input  wire logic         reset_n,
  input  wire logic         i_load,
  input  wire logic         i_dec,
  output logic [W-1:0]      o_count,
  output logic              o_zero
);

  logic [W-1:0] r_count;

  // Saturates at zero so a stray decrement can never wrap the index
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= W'(NR);
    end else if (i_load) begin
      r_count <= W'(NR - 1);
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/aes_dec_round_ctrl.sv
// ============================================================================
// Module      : aes_dec_round_ctrl
// Description : Inverse-cipher sequencer pulsing AES decrypt stage starts.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes_dec_round_ctrl
  import aes_dec_pkg::*;
#(
  parameter int NR     = NR_DEF,
  parameter int KIDX_W = aes_dec_pkg::KIDX_W
) (
  input wire logic             clk,
  input wire logic             reset_n,
  aes_dec_round_ctrl_if.slave  bus
);

  state_t            r_state;
  state_t            w_next;
  logic              r_from_imc;
  logic              w_load;
  logic              w_dec;
  logic              w_zero;
  logic [KIDX_W-1:0] w_count;
  logic              w_in_ready;
  logic              w_isr;
  logic              w_isb;
  logic              w_ark;
  logic              w_imc;
  logic [SRC_W-1:0]  w_src;
  logic [KIDX_W-1:0] w_key;

  aes_round_counter #(
    .NR (NR),
    .W  (KIDX_W)
  ) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_load),
    .i_dec   (w_dec),
    .o_count (w_count),
    .o_zero  (w_zero)
  );

  // r_from_imc picks the ISR source: ARK output on round entry, IMC otherwise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_from_imc <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_from_imc <= (r_state == ST_IMC);
    end
  end

  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    w_isr      = 1'b0;
    w_isb      = 1'b0;
    w_ark      = 1'b0;
    w_imc      = 1'b0;
    w_src      = SRC_IN;
    w_key      = '0;
    w_load     = 1'b0;
    w_dec      = 1'b0;
    if (bus.abort && (r_state != ST_IDLE)) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_in_ready = bus.key_ready;
          if (bus.in_valid && bus.key_ready) w_next = ST_ARK0;
        end
        ST_ARK0: begin
          w_ark  = 1'b1;
          w_key  = KIDX_W'(NR);
          w_load = 1'b1;
          w_next = ST_ISR;
        end
        ST_ISR: begin
          w_isr  = 1'b1;
          w_src  = r_from_imc ? SRC_IMC : SRC_ARK;
          w_next = ST_ISB;
        end
        ST_ISB: begin
          w_isb  = 1'b1;
          w_src  = SRC_ISR;
          w_next = ST_ARK;
        end
        ST_ARK: begin
          w_ark  = 1'b1;
          w_src  = SRC_ISB;
          w_key  = w_count;
          w_next = w_zero ? ST_DONE : ST_IMC;
        end
        ST_IMC: begin
          w_imc  = 1'b1;
          w_src  = SRC_ARK;
          w_dec  = 1'b1;
          w_next = ST_ISR;
        end
        ST_DONE: begin
          w_in_ready = bus.out_ready && bus.key_ready;
          if (bus.out_ready) begin
            w_next = (bus.in_valid && bus.key_ready) ? ST_ARK0 : ST_IDLE;
          end
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.isr_start = w_isr;
  assign bus.isb_start = w_isb;
  assign bus.ark_start = w_ark;
  assign bus.imc_start = w_imc;
  assign bus.src_sel   = w_src;
  assign bus.key_idx   = w_key;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: doc/aes_dec_round_ctrl.md
Name: aes_dec_round_ctrl

Overview:
- Sequencer for the AES-128 inverse-cipher datapath.
- The datapath is built from registered one-cycle stages: inverse shift row, inverse sub bytes, add round key and inverse mix columns. Each stage captures its input when its start is high and holds otherwise.
- This block accepts a ciphertext-block request, pulses each stage start in FIPS-197 inverse-cipher order, and drives the round-key index and the stage-input mux select. It presents a valid/ready result handshake and sits between the top-level decrypt wrapper and the stage registers.

Parameters:
- NR, 10, number of cipher rounds; round-key index runs NR down to 0.
- KIDX_W, 4, width of the round-key index output.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- key_ready  in  1  expanded key schedule is valid; gates acceptance.
- in_valid  in  1  ciphertext block present on the datapath input.
- in_ready  out  1  controller can accept a block this cycle.
- abort  in  1  synchronous cancel of the current block.
- isr_start  out  1  inverse shift row stage enable.
- isb_start  out  1  inverse sub bytes stage enable.
- ark_start  out  1  add round key stage enable.
- imc_start  out  1  inverse mix columns stage enable.
- src_sel  out  3  stage-input mux: 0 = input block, 1 = ISR out, 2 = ISB out, 3 = ARK out, 4 = IMC out.
- key_idx  out  KIDX_W  round key selected for the add round key stage.
- busy  out  1  a block is in flight.
- out_valid  out  1  ARK output register holds the plaintext.
- out_ready  in  1  consumer takes the plaintext.

Behaviour:
- Reset (async, reset_n low): state = IDLE, round counter = NR, key_idx = 0. All starts, busy and out_valid are 0; src_sel = 0. Reset mid-operation discards the block silently.
- Clock and reset: one clock (clk); reset is asynchronous and active-low (reset_n).
- Start outputs are decoded from state, are one-hot or all-zero, and are high for exactly one cycle per state visit.
- FSM states: IDLE, ARK0, ISR, ISB, ARK, IMC, DONE.
- IDLE: in_ready = key_ready. On in_valid & in_ready, go to ARK0.
- ARK0: ark_start = 1, src_sel = 0, key_idx = NR. Round counter loads NR-1. Go to ISR.
- ISR: isr_start = 1. src_sel = 4 if coming from IMC, else 3. Go to ISB.
- ISB: isb_start = 1, src_sel = 1. Go to ARK.
- ARK: ark_start = 1, src_sel = 2, key_idx = round counter.
  - Counter != 0: go to IMC.
  - Counter == 0: go to DONE.
- IMC: imc_start = 1, src_sel = 3. Decrement the round counter. Go to ISR.
- DONE: out_valid = 1; no starts asserted.
  - in_ready = out_ready & key_ready (back-to-back acceptance).
  - out_ready & in_valid & in_ready: go to ARK0 in the same cycle.
  - out_ready only: go to IDLE.
  - Otherwise hold and keep out_valid high.
- Latency: accept in cycle 0.
  - ARK0 in cycle 1.
  - Rounds NR-1..1 take 4 cycles each (cycles 2-37).
  - Final ISR/ISB/ARK in cycles 38-40.
  - out_valid high from cycle 41. Total = 4*NR+1 cycles after accept.
- busy = 1 in every state except IDLE.
- Counter never underflows: the ARK state with counter 0 always exits to DONE.
- abort, synchronous, highest priority after reset: from any state go to IDLE with no starts that cycle. out_valid drops next cycle and the in-flight result is lost. abort in IDLE has no effect.
- key_ready low while busy has no effect. The schedule must stay stable; key_ready is checked only at acceptance.
- in_valid while busy (not DONE) is ignored; in_ready = 0.

Decomposition:
- Package aes_dec_pkg holds:
  - the state enum;
  - src_sel encodings (SRC_IN, SRC_ISR, SRC_ISB, SRC_ARK, SRC_IMC);
  - the NR default;
  - the KIDX_W constant.
- One natural sub-module: aes_round_counter, a down-counter with load NR-1, decrement enable and zero flag.
- FSM and output decode stay in the top block.

Test Plan:
- Single block, key_ready = 1, out_ready = 1: accept at cycle 0.
  - Start sequence is ARK, then (ISR, ISB, ARK, IMC) x9, then ISR, ISB, ARK.
  - key_idx at the ARK pulses is 10, 9, 8, …, 1, 0.
  - out_valid = 1 at cycle 41 for one cycle.
- Integration with stage stubs replaced by the real stages: key 000102030405060708090a0b0c0d0e0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a -> plaintext 00112233445566778899aabbccddeeff at out_valid.
- key_ready = 0 with in_valid = 1 for 20 cycles -> in_ready = 0, no starts, busy = 0. Raise key_ready -> accept next cycle.
- Backpressure: out_ready = 0 for 10 cycles after DONE -> out_valid held, no starts. Then out_ready = 1 with in_valid = 1 -> new ARK0 next cycle with key_idx = 10, no IDLE gap.
- abort asserted at cycle 15 (mid round 6) -> no starts from cycle 15. IDLE and busy = 0 at cycle 16; out_valid never asserted.
- reset_n pulsed low at cycle 20 -> all outputs 0 immediately (async). After release, the next block completes normally in 41 cycles.
